// File: rtl/register_file.sv
// register_file: 32 x N_BITS MIPS GPR file; reg 0 reads as zero, $gp/$sp preset on reset; optional REGFILE_BYPASS_EN.
// Latency: reads are combinational, a write is visible from the rising edge that captures it.
// Backpressure: none; a write is accepted on every rising edge while reset is high.
module register_file #(
    parameter int                N_BITS  = 32,
    parameter logic [N_BITS-1:0] SP_INIT = 32'h7FFF_EFFC,
    parameter logic [N_BITS-1:0] GP_INIT = 32'h1000_8000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [4:0]        WriteRegister,
    input  logic [N_BITS-1:0] WriteData,
    input  logic [4:0]        ReadRegister1,
    input  logic [4:0]        ReadRegister2,
    output logic [N_BITS-1:0] ReadData1,
    output logic [N_BITS-1:0] ReadData2
);

    localparam int GP_IDX = 28;
    localparam int SP_IDX = 29;

    // Register 0 has no flop; entry 0 of this vector is a constant zero.
    logic [N_BITS-1:0] regs [32];
    logic              wr_en;

    assign wr_en   = reset && RegWrite && (WriteRegister != 5'd0);
    assign regs[0] = '0;

    for (genvar g = 1; g < 32; g++) begin : g_reg
        localparam logic [N_BITS-1:0] RST_VAL =
            (g == GP_IDX) ? GP_INIT :
            (g == SP_IDX) ? SP_INIT : '0;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                regs[g] <= RST_VAL;
            end else if (wr_en && (WriteRegister == 5'(g))) begin
                regs[g] <= WriteData;
            end
        end
    end

    logic [N_BITS-1:0] stored1;
    logic [N_BITS-1:0] stored2;

    assign stored1 = regs[ReadRegister1];
    assign stored2 = regs[ReadRegister2];

`ifdef REGFILE_BYPASS_EN
    // wr_en already excludes reset and reg 0, so neither ever forwards.
    logic hit1;
    logic hit2;

    assign hit1 = wr_en && (WriteRegister == ReadRegister1);
    assign hit2 = wr_en && (WriteRegister == ReadRegister2);

    always_comb begin
        ReadData1 = stored1;
        ReadData2 = stored2;
        if (hit1) begin
            ReadData1 = WriteData;
        end
        if (hit2) begin
            ReadData2 = WriteData;
        end
    end
`else
    always_comb begin
        ReadData1 = stored1;
        ReadData2 = stored2;
    end
`endif

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed vector table, corner sequences, random traffic vs array model.
module tb_register_file;

    localparam logic [31:0] SP = 32'h7FFF_EFFC;
    localparam logic [31:0] GP = 32'h1000_8000;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        RegWrite = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData = '0;
    logic [4:0]  ReadRegister1 = '0;
    logic [4:0]  ReadRegister2 = '0;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;

    int total = 0;
    int bad = 0;

    logic [31:0] model [32];

    register_file dut (
        .clk           (clk),
        .reset         (reset),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] old1;
        logic [31:0] old2;
        logic [31:0] new1;
        logic [31:0] new2;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        model[28] = GP;
        model[29] = SP;
    endfunction

    // Value a read port must show before the edge, from the spec's forwarding rule.
    function automatic logic [31:0] pre_value(input logic we, input logic [4:0] wa,
                                              input logic [31:0] wd, input logic [4:0] ra,
                                              input logic [31:0] old);
        if (BYP && reset && we && wa != 5'd0 && wa == ra) return wd;
        return old;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] ra1, input logic [4:0] ra2);
        RegWrite      = we;
        WriteRegister = wa;
        WriteData     = wd;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd8,  32'd0, 32'd0,        32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'd0, 32'd0,        32'd0,         32'd0};
        vecs[2] = '{1'b1, 5'd9,  32'd5,         5'd9,  5'd29, 32'd0, SP,           32'd5,         SP};
        vecs[3] = '{1'b1, 5'd9,  32'd7,         5'd9,  5'd8,  32'd5, 32'hDEAD_BEEF, 32'd7,        32'hDEAD_BEEF};
        vecs[4] = '{1'b0, 5'd9,  32'h0000_AAAA, 5'd9,  5'd28, 32'd7, GP,           32'd7,         GP};
        vecs[5] = '{1'b1, 5'd31, 32'd1,         5'd31, 5'd1,  32'd0, 32'd0,        32'd1,         32'd0};
        vecs[6] = '{1'b1, 5'd29, 32'h0000_1234, 5'd29, 5'd28, SP,    GP,           32'h0000_1234, GP};

        // Reset takes effect with no clock edge: drop it at t=3, check at t=4.
        #3 reset = 1'b0;
        #1;
        drive(1'b0, 5'd0, 32'd0, 5'd29, 5'd28);
        #0.1;
        check("rst_sp", ReadData1, SP);
        check("rst_gp", ReadData2, GP);
        drive(1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
        #0.1;
        check("rst_r1", ReadData1, 32'd0);
        check("rst_r31", ReadData2, 32'd0);
        // Writes are ignored while reset is held, even across edges.
        drive(1'b1, 5'd5, 32'hBAD0_BAD0, 5'd5, 5'd0);
        @(posedge clk); #1;
        check("rst_hold_wr", ReadData1, 32'd0);
        check("rst_zero", ReadData2, 32'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        reset = 1'b1;

        // Directed table, one edge per vector.
        for (int v = 0; v < 7; v++) begin
            @(negedge clk);
            drive(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].ra2);
            #1;
            check($sformatf("vec%0d_pre1", v), ReadData1,
                  pre_value(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra1, vecs[v].old1));
            check($sformatf("vec%0d_pre2", v), ReadData2,
                  pre_value(vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra2, vecs[v].old2));
            @(posedge clk); #1;
            check($sformatf("vec%0d_post1", v), ReadData1, vecs[v].new1);
            check($sformatf("vec%0d_post2", v), ReadData2, vecs[v].new2);
        end

        // Reset dropped just before the edge overrides the pending write.
        @(negedge clk);
        drive(1'b1, 5'd10, 32'h0000_1234, 5'd10, 5'd29);
        #3 reset = 1'b0;
        #1;
        check("midrst_pre_r10", ReadData1, 32'd0);
        check("midrst_sp", ReadData2, SP);
        @(posedge clk); #1;
        check("midrst_post_r10", ReadData1, 32'd0);
        check("midrst_r9_cleared", dut.regs[9], 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_rel_pre", ReadData1, BYP ? 32'h0000_1234 : 32'd0);
        @(posedge clk); #1;
        check("midrst_first_wr", ReadData1, 32'h0000_1234);
        @(negedge clk);
        drive(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);

        // Independence: k*3 into every register, then every read pair.
        for (int k = 1; k < 32; k++) begin
            @(negedge clk);
            drive(1'b1, 5'(k), 32'(k * 3), 5'd0, 5'd0);
        end
        @(negedge clk);
        drive(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        @(negedge clk);
        RegWrite = 1'b0;
        for (int a = 0; a < 32; a++) begin
            for (int b = 0; b < 32; b++) begin
                ReadRegister1 = 5'(a);
                ReadRegister2 = 5'(b);
                #0.1;
                check($sformatf("indep_p1_%0d", a), ReadData1, 32'(a * 3));
                check($sformatf("indep_p2_%0d", b), ReadData2, 32'(b * 3));
            end
        end

        // Random traffic against an array model, starting from a fresh reset.
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic        we;
            logic [4:0]  wa, ra1, ra2;
            logic [31:0] wd;
            @(negedge clk);
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(we, wa, wd, ra1, ra2);
            #1;
            check("rand_pre1", ReadData1, pre_value(we, wa, wd, ra1, model[ra1]));
            check("rand_pre2", ReadData2, pre_value(we, wa, wd, ra2, model[ra2]));
            @(posedge clk);
            if (we && wa != 5'd0) model[wa] = wd;
            #1;
            ReadRegister1 = 5'($urandom_range(0, 31));
            ReadRegister2 = 5'($urandom_range(0, 31));
            RegWrite = 1'b0;
            #0.1;
            check("rand_post1", ReadData1, model[ReadRegister1]);
            check("rand_post2", ReadData2, model[ReadRegister2]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
